// File: rtl/sms_rx_pkg.sv
// Shared types and constants for the SDTRL receiver: event record, idle level, index width helper.
package sms_rx_pkg;

    localparam logic SDTRL_IDLE = 1'b1;
    localparam int   MAXCH      = 16;
    localparam int   CHW        = 4;

    typedef struct packed {
        logic [CHW-1:0] chan;
        logic           level;
    } sms_evt_t;

    // Index width that never collapses to zero for a single channel.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sms_sdtrl_receiver_if.sv
// Change-event valid/ready port of the SDTRL receiver; master side presents events.
interface sms_sdtrl_receiver_if #(
    parameter int CHANNELS = 4
);
    import sms_rx_pkg::*;

    localparam int CW = clog2_min1(CHANNELS);

    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] evt_chan;
    logic          evt_level;

    modport master (output evt_valid, output evt_chan, output evt_level, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_chan, input  evt_level, output evt_ready);

endinterface

// File: rtl/sms_rx_filter_chan.sv
// One SDTRL line: synchroniser, deglitch counter, accepted level and same-cycle update strobe.
// Edge pulse flops exist only when SMS_RX_EDGE_EN is defined; otherwise rise/fall are tied low.
module sms_rx_filter_chan
    import sms_rx_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level_out,
    output logic upd,
    output logic rise,
    output logic fall
);

    localparam int              CNTW     = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNTW-1:0]        r_cnt;
    logic                   r_level;
    logic                   w_s;
    logic                   w_upd;

    assign w_s   = r_sync[SYNC_STAGES-1];
    assign w_upd = (w_s != r_level) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{SDTRL_IDLE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], line_in};
        end
    end

    // Any sample agreeing with the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= SDTRL_IDLE;
        end else if (w_s == r_level) begin
            r_cnt   <= '0;
        end else if (w_upd) begin
            r_cnt   <= '0;
            r_level <= w_s;
        end else begin
            r_cnt   <= r_cnt + CNTW'(1);
        end
    end

    assign level_out = r_level;
    assign upd       = w_upd;

`ifdef SMS_RX_EDGE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_upd &  w_s;
            r_fall <= w_upd & ~w_s;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/sms_sdtrl_receiver.sv
// SDTRL receiver top: per-line filters, pending/overrun tracking, fixed-priority event port.
// Optional macro SMS_RX_EDGE_EN enables registered rise/fall pulses.
module sms_sdtrl_receiver
    import sms_rx_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] line_in,
    output logic [CHANNELS-1:0] level_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] overrun,
    sms_sdtrl_receiver_if.master evt
);

    localparam int CW = clog2_min1(CHANNELS);

    logic [CHANNELS-1:0] w_upd;
    logic [CHANNELS-1:0] w_acc_vec;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_overrun;
    logic [MAXCH-1:0]    w_lvl_pad;
    logic                w_acc;
    sms_evt_t            w_evt;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        sms_rx_filter_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .line_in   (line_in[g]),
            .level_out (level_out[g]),
            .upd       (w_upd[g]),
            .rise      (rise[g]),
            .fall      (fall[g])
        );
    end

    assign w_lvl_pad = MAXCH'(level_out);

    // Lowest pending index wins; scanning downward leaves the smallest set index.
    always_comb begin
        w_evt = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_evt.chan = CHW'(i);
            end
        end
        w_evt.level = w_lvl_pad[w_evt.chan];
    end

    assign w_acc = evt.evt_valid && evt.evt_ready;

    always_comb begin
        w_acc_vec = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_acc_vec[i] = w_acc && (w_evt.chan == CHW'(i));
        end
    end

    // A new change always wins over an accept on the same channel and leaves overrun alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_upd[i]) begin
                    r_pending[i] <= 1'b1;
                    if (r_pending[i] && !w_acc_vec[i]) begin
                        r_overrun[i] <= 1'b1;
                    end
                end else if (w_acc_vec[i]) begin
                    r_pending[i] <= 1'b0;
                    r_overrun[i] <= 1'b0;
                end
            end
        end
    end

    assign evt.evt_valid = |r_pending;
    assign evt.evt_chan  = w_evt.chan[CW-1:0];
    assign evt.evt_level = w_evt.level;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_sms_sdtrl_receiver.sv
// Bench for sms_sdtrl_receiver: directed scenarios plus randomized traffic against a window model.
module tb_sms_sdtrl_receiver;
    import sms_rx_pkg::*;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int FC = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] line_in;
    logic [CH-1:0] level_out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] overrun;

    sms_sdtrl_receiver_if #(.CHANNELS(CH)) evt_if ();

    sms_sdtrl_receiver #(
        .CHANNELS      (CH),
        .SYNC_STAGES   (SS),
        .FILTER_CYCLES (FC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .line_in   (line_in),
        .level_out (level_out),
        .rise      (rise),
        .fall      (fall),
        .overrun   (overrun),
        .evt       (evt_if)
    );

    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference: history of raw samples; a line flips once the last FC synchronised samples
    // all disagree with its accepted level.
    logic [CH-1:0] q[$];
    logic [CH-1:0] m_level, m_pend, m_ov, m_rise, m_fall;

    function automatic int lowest(input logic [CH-1:0] p);
        for (int i = 0; i < CH; i++) if (p[i]) return i;
        return 0;
    endfunction

    function automatic logic [CH-1:0] exp_edge(input logic [CH-1:0] e);
`ifdef SMS_RX_EDGE_EN
        return e;
`else
        return (e & '0);
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < SS + FC; i++) q.push_back({CH{1'b1}});
        m_level = '1; m_pend = '0; m_ov = '0; m_rise = '0; m_fall = '0;
    endtask

    task automatic step();
        logic [CH-1:0] s, upd, nl;
        bit acc;
        int ach;
        @(posedge clk);
        acc = evt_if.evt_ready && (m_pend != '0);
        ach = lowest(m_pend);
        q.push_back(line_in);
        upd = '1;
        for (int k = 1; k <= FC; k++) begin
            s = q[k];
            upd &= s ^ m_level;
        end
        void'(q.pop_front());
        nl = m_level ^ upd;
        m_rise = upd & nl;
        m_fall = upd & ~nl;
        for (int c = 0; c < CH; c++) begin
            if (upd[c]) begin
                if (m_pend[c] && !(acc && ach == c)) m_ov[c] = 1'b1;
                m_pend[c] = 1'b1;
            end else if (acc && ach == c) begin
                m_pend[c] = 1'b0;
                m_ov[c]   = 1'b0;
            end
        end
        m_level = nl;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; line_in = '0; evt_if.evt_ready = 1'b0;
        #2 rst_n = 1'b0;
        #10;
        model_reset();
        n_vec++; if (level_out !== 4'b1111) begin n_err++; $display("FAIL reset_level got %b want 1111", level_out); end
        n_vec++; if (evt_if.evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", evt_if.evt_valid); end
        n_vec++; if ({overrun, rise, fall} !== 12'h0) begin n_err++; $display("FAIL reset_flags got %h want 000", {overrun, rise, fall}); end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9) begin
                n_vec++; if (level_out !== 4'b1111) begin n_err++; $display("FAIL lat_clk9 got %b want 1111", level_out); end
            end
            if (k == 10) begin
                n_vec++; if (level_out !== 4'b0000) begin n_err++; $display("FAIL lat_clk10 got %b want 0000", level_out); end
                n_vec++; if (evt_if.evt_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid got %b want 1", evt_if.evt_valid); end
            end
        end
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < CH; i++) begin
            n_vec++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_chan !== 2'(i) || evt_if.evt_level !== 1'b0) begin
                n_err++; $display("FAIL drain_order v=%b chan=%0d lvl=%b want v=1 chan=%0d lvl=0",
                                  evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_level, i);
            end
            step();
        end
        n_vec++; if (evt_if.evt_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", evt_if.evt_valid); end
        evt_if.evt_ready = 1'b0;
    endtask

    task automatic test_glitch();
        bit saw;
        line_in = '1; evt_if.evt_ready = 1'b1;
        repeat (16) step();
        evt_if.evt_ready = 1'b0;
        n_vec++; if (level_out !== 4'b1111 || evt_if.evt_valid !== 1'b0) begin
            n_err++; $display("FAIL idle_settle lvl=%b v=%b want 1111/0", level_out, evt_if.evt_valid); end
        line_in[2] = 1'b0;
        repeat (7) step();
        line_in[2] = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (level_out !== 4'b1111 || evt_if.evt_valid !== 1'b0 || rise !== 4'b0 || fall !== 4'b0) saw = 1'b1;
        end
        n_vec++; if (saw !== 1'b0) begin n_err++; $display("FAIL glitch7 activity=%b want 0", saw); end
        line_in[2] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 8) line_in[2] = 1'b1;
            if (k == 9) begin
                n_vec++; if (level_out !== 4'b1111 || fall !== 4'b0) begin
                    n_err++; $display("FAIL glitch8_clk9 lvl=%b fall=%b want 1111/0000", level_out, fall); end
            end
            if (k == 10) begin
                n_vec++; if (level_out !== 4'b1011) begin n_err++; $display("FAIL glitch8_lvl got %b want 1011", level_out); end
                n_vec++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_chan !== 2'd2 || evt_if.evt_level !== 1'b0) begin
                    n_err++; $display("FAIL glitch8_evt v=%b chan=%0d lvl=%b want 1/2/0",
                                      evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_level); end
                n_vec++; if (fall !== exp_edge(4'b0100) || rise !== 4'b0) begin
                    n_err++; $display("FAIL edge_fall fall=%b rise=%b want %b/0000", fall, rise, exp_edge(4'b0100)); end
            end
            if (k == 11) begin
                n_vec++; if (fall !== 4'b0) begin n_err++; $display("FAIL edge_fall_width got %b want 0000", fall); end
            end
            if (k == 18) begin
                n_vec++; if (level_out !== 4'b1111 || rise !== exp_edge(4'b0100)) begin
                    n_err++; $display("FAIL edge_rise lvl=%b rise=%b want 1111/%b", level_out, rise, exp_edge(4'b0100)); end
            end
        end
        evt_if.evt_ready = 1'b1;
        repeat (3) step();
        evt_if.evt_ready = 1'b0;
        n_vec++; if (evt_if.evt_valid !== 1'b0 || overrun !== 4'b0) begin
            n_err++; $display("FAIL glitch_drain v=%b ov=%b want 0/0000", evt_if.evt_valid, overrun); end
    endtask

    task automatic test_backpressure();
        evt_if.evt_ready = 1'b0;
        line_in[1] = 1'b0;
        repeat (12) step();
        line_in[1] = 1'b1;
        repeat (22) step();
        n_vec++; if (overrun !== 4'b0010) begin n_err++; $display("FAIL bp_overrun got %b want 0010", overrun); end
        n_vec++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_chan !== 2'd1 || evt_if.evt_level !== 1'b1) begin
            n_err++; $display("FAIL bp_evt v=%b chan=%0d lvl=%b want 1/1/1",
                              evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_level); end
        evt_if.evt_ready = 1'b1;
        step();
        evt_if.evt_ready = 1'b0;
        n_vec++; if (evt_if.evt_valid !== 1'b0 || overrun !== 4'b0) begin
            n_err++; $display("FAIL bp_clear v=%b ov=%b want 0/0000", evt_if.evt_valid, overrun); end
    endtask

    task automatic test_accept_collide();
        evt_if.evt_ready = 1'b0;
        line_in[0] = 1'b0;
        repeat (12) step();
        line_in[0] = 1'b1;
        repeat (9) step();
        evt_if.evt_ready = 1'b1;
        step();
        evt_if.evt_ready = 1'b0;
        n_vec++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_chan !== 2'd0 || evt_if.evt_level !== 1'b1) begin
            n_err++; $display("FAIL collide_pend v=%b chan=%0d lvl=%b want 1/0/1",
                              evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_level); end
        n_vec++; if (overrun[0] !== 1'b0 || level_out[0] !== 1'b1) begin
            n_err++; $display("FAIL collide_ov ov0=%b lvl0=%b want 0/1", overrun[0], level_out[0]); end
        evt_if.evt_ready = 1'b1;
        step();
        evt_if.evt_ready = 1'b0;
        n_vec++; if (evt_if.evt_valid !== 1'b0) begin n_err++; $display("FAIL collide_drain got %b want 0", evt_if.evt_valid); end
    endtask

    task automatic test_reset_mid();
        evt_if.evt_ready = 1'b0;
        line_in = 4'b1001;
        repeat (12) step();
        line_in = 4'b0001;
        repeat (7) step();
        n_vec++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_chan !== 2'd1 || m_pend !== 4'b0110) begin
            n_err++; $display("FAIL midrst_pre v=%b chan=%0d want 1/1 (model pend %b)",
                              evt_if.evt_valid, evt_if.evt_chan, m_pend); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (level_out !== 4'b1111 || evt_if.evt_valid !== 1'b0 || {overrun, rise, fall} !== 12'h0) begin
            n_err++; $display("FAIL midrst_async lvl=%b v=%b flags=%h want 1111/0/000",
                              level_out, evt_if.evt_valid, {overrun, rise, fall}); end
        model_reset();
        line_in = '1;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) step();
        n_vec++; if (level_out !== 4'b1111 || evt_if.evt_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_after lvl=%b v=%b want 1111/0", level_out, evt_if.evt_valid); end
    endtask

    task automatic test_random();
        int  hold[CH];
        bit  rdy_mode;
        int  lc;
        for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 14);
        rdy_mode = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            step();
            n_vec++;
            if (level_out !== m_level || overrun !== m_ov || evt_if.evt_valid !== (m_pend != '0) ||
                rise !== exp_edge(m_rise) || fall !== exp_edge(m_fall)) begin
                n_err++; $display("FAIL rnd_state t=%0d lvl=%b ov=%b v=%b r=%b f=%b want %b/%b/%b/%b/%b", t,
                                  level_out, overrun, evt_if.evt_valid, rise, fall,
                                  m_level, m_ov, (m_pend != '0), exp_edge(m_rise), exp_edge(m_fall));
            end
            if (m_pend != '0) begin
                lc = lowest(m_pend);
                n_vec++;
                if (evt_if.evt_chan !== 2'(lc) || evt_if.evt_level !== m_level[lc]) begin
                    n_err++; $display("FAIL rnd_evt t=%0d chan=%0d lvl=%b want %0d/%b", t,
                                      evt_if.evt_chan, evt_if.evt_level, lc, m_level[lc]);
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    line_in[c] = ~line_in[c];
                    hold[c] = $urandom_range(1, 14);
                end else begin
                    hold[c]--;
                end
            end
            if ($urandom_range(0, 15) == 0) rdy_mode = ~rdy_mode;
            evt_if.evt_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : 1'b0;
        end
        evt_if.evt_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_glitch();
        test_backpressure();
        test_accept_collide();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
